// File: rtl/audio_recorder_ctrl.sv
// rtl/audio_recorder_ctrl.sv - left-channel codec ADC capture to SRAM with record/pause/full status
module audio_recorder_ctrl #(
  parameter logic [19:0] ADDR_MAX    = 20'hFFFFF,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_pause,
  input  logic        i_stop,
  input  logic        i_aud_bclk,
  input  logic        i_aud_adclrck,
  input  logic        i_aud_adcdat,
  output logic [19:0] o_sram_addr,
  output logic [15:0] o_sram_data,
  output logic        o_sram_we_n,
  output logic [3:0]  o_state,
  output logic [19:0] o_addr,
  output logic [15:0] o_record_data,
  output logic        o_full
);

  // Encodings match what the LED block decodes: [0]=active, [1]=paused, [2]=write mode.
  typedef enum logic [3:0] {
    S_IDLE   = 4'b0000,
    S_RECORD = 4'b0101,
    S_PAUSE  = 4'b0110,
    S_FULL   = 4'b0100
  } state_t;

  state_t r_state, w_next_state;

  logic [SYNC_STAGES-1:0] r_bclk_sync, r_lr_sync, r_dat_sync;
  logic        r_bclk_d, r_lr_d;
  logic        r_armed;
  logic [4:0]  r_bit_cnt;
  logic [15:0] r_shift;
  logic [19:0] r_sram_addr, r_addr;
  logic [15:0] r_sram_data, r_record_data;
  logic        r_sram_we_n, r_full;

  logic        w_bclk, w_lr, w_dat, w_bclk_rise, w_lr_fall;
  logic        w_recording, w_bit_take, w_word_done, w_write_go, w_clear_addr;
  logic [15:0] w_sample;

  assign w_bclk      = r_bclk_sync[SYNC_STAGES-1];
  assign w_lr        = r_lr_sync[SYNC_STAGES-1];
  assign w_dat       = r_dat_sync[SYNC_STAGES-1];
  assign w_bclk_rise = w_bclk & ~r_bclk_d;
  assign w_lr_fall   = ~w_lr & r_lr_d;

  assign w_recording  = (r_state == S_RECORD);
  assign w_bit_take   = w_recording && r_armed && w_bclk_rise && !w_lr_fall && (r_bit_cnt < 5'd16);
  assign w_word_done  = w_bit_take && (r_bit_cnt == 5'd15);
  assign w_sample     = {r_shift[14:0], w_dat};
  // A pause/stop on the completing cycle moves the FSM away and drops the word.
  assign w_write_go   = w_word_done && (w_next_state == S_RECORD);
  assign w_clear_addr = ((r_state == S_IDLE) || (r_state == S_FULL)) && (w_next_state == S_RECORD);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bclk_sync <= '0;
      r_lr_sync   <= '0;
      r_dat_sync  <= '0;
      r_bclk_d    <= 1'b0;
      r_lr_d      <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], i_aud_bclk};
      r_lr_sync   <= {r_lr_sync[SYNC_STAGES-2:0], i_aud_adclrck};
      r_dat_sync  <= {r_dat_sync[SYNC_STAGES-2:0], i_aud_adcdat};
      r_bclk_d    <= w_bclk;
      r_lr_d      <= w_lr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_armed   <= 1'b0;
      r_bit_cnt <= 5'd0;
      r_shift   <= 16'd0;
    end else if (!w_recording) begin
      r_armed   <= 1'b0;
      r_bit_cnt <= 5'd0;
    end else if (w_lr_fall) begin
      r_armed   <= 1'b1;
      r_bit_cnt <= 5'd0;
    end else if (w_bit_take) begin
      r_shift   <= w_sample;
      r_bit_cnt <= r_bit_cnt + 5'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (!i_stop && !i_pause && i_start) w_next_state = S_RECORD;
      S_RECORD: begin
        if (i_stop)                                         w_next_state = S_IDLE;
        else if (i_pause)                                   w_next_state = S_PAUSE;
        else if (!r_sram_we_n && (r_sram_addr == ADDR_MAX)) w_next_state = S_FULL;
      end
      S_PAUSE: begin
        if (i_stop)       w_next_state = S_IDLE;
        else if (i_pause) w_next_state = S_RECORD;
      end
      S_FULL: begin
        if (i_stop)                   w_next_state = S_IDLE;
        else if (!i_pause && i_start) w_next_state = S_RECORD;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sram_addr   <= 20'd0;
      r_sram_data   <= 16'd0;
      r_sram_we_n   <= 1'b1;
      r_addr        <= 20'd0;
      r_record_data <= 16'd0;
      r_full        <= 1'b0;
    end else begin
      r_sram_we_n <= 1'b1;
      r_full      <= (w_next_state == S_FULL);
      if (w_clear_addr) begin
        r_addr        <= 20'd0;
        r_record_data <= 16'd0;
      end else if (!r_sram_we_n) begin
        r_addr <= (r_sram_addr == ADDR_MAX) ? ADDR_MAX : r_addr + 20'd1;
      end
      if (w_write_go) begin
        r_sram_we_n   <= 1'b0;
        r_sram_addr   <= r_addr;
        r_sram_data   <= w_sample;
        r_record_data <= w_sample;
      end
    end
  end

  assign o_sram_addr   = r_sram_addr;
  assign o_sram_data   = r_sram_data;
  assign o_sram_we_n   = r_sram_we_n;
  assign o_state       = r_state;
  assign o_addr        = r_addr;
  assign o_record_data = r_record_data;
  assign o_full        = r_full;

endmodule

// File: tb/tb_audio_recorder_ctrl.sv
// tb/tb_audio_recorder_ctrl.sv - directed bench with write scoreboards for audio_recorder_ctrl
module tb_audio_recorder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, pause_a, stop_a, start_b, pause_b, stop_b;
  logic bclk, lrck, dat;

  logic [19:0] a_sram_addr, a_addr, b_sram_addr, b_addr;
  logic [15:0] a_sram_data, a_rec, b_sram_data, b_rec;
  logic        a_we_n, a_full, b_we_n, b_full;
  logic [3:0]  a_state, b_state;

  audio_recorder_ctrl dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_pause(pause_a), .i_stop(stop_a),
    .i_aud_bclk(bclk), .i_aud_adclrck(lrck), .i_aud_adcdat(dat),
    .o_sram_addr(a_sram_addr), .o_sram_data(a_sram_data), .o_sram_we_n(a_we_n),
    .o_state(a_state), .o_addr(a_addr), .o_record_data(a_rec), .o_full(a_full)
  );

  audio_recorder_ctrl #(.ADDR_MAX(20'd2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_pause(pause_b), .i_stop(stop_b),
    .i_aud_bclk(bclk), .i_aud_adclrck(lrck), .i_aud_adcdat(dat),
    .o_sram_addr(b_sram_addr), .o_sram_data(b_sram_data), .o_sram_we_n(b_we_n),
    .o_state(b_state), .o_addr(b_addr), .o_record_data(b_rec), .o_full(b_full)
  );

  int total = 0;
  int bad   = 0;
  logic [35:0] q_a[$];
  logic [35:0] q_b[$];

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic        a_prev_low = 1'b0, b_prev_low = 1'b0;
  logic [35:0] a_e, b_e;
  always @(negedge clk) begin
    if (a_we_n === 1'b0) begin
      check("a_we_single", 36'(a_prev_low), 36'd0);
      if (q_a.size() == 0) begin
        total++; bad++;
        $error("FAIL a_unexpected_write observed=%0h expected=none", {a_sram_addr, a_sram_data});
      end else begin
        a_e = q_a.pop_front();
        check("a_write", {a_sram_addr, a_sram_data}, a_e);
      end
    end
    if (b_we_n === 1'b0) begin
      check("b_we_single", 36'(b_prev_low), 36'd0);
      if (q_b.size() == 0) begin
        total++; bad++;
        $error("FAIL b_unexpected_write observed=%0h expected=none", {b_sram_addr, b_sram_data});
      end else begin
        b_e = q_b.pop_front();
        check("b_write", {b_sram_addr, b_sram_data}, b_e);
      end
    end
    a_prev_low = (a_we_n === 1'b0);
    b_prev_low = (b_we_n === 1'b0);
  end

  // All stimulus changes land on clk falling-edge times; posedges sit 5 ns away.
  task automatic send_bit(input logic b);
    dat = b; #40; bclk = 1'b1; #40; bclk = 1'b0;
  endtask

  task automatic cmd(input logic sa, pa, ta, sb, pb, tb);
    start_a = sa; pause_a = pa; stop_a = ta; start_b = sb; pause_b = pb; stop_b = tb;
    #10;
    start_a = 0; pause_a = 0; stop_a = 0; start_b = 0; pause_b = 0; stop_b = 0;
  endtask

  // mode 0 plain, 1 stop_a on word-complete cycle, 2 reset on write cycle, 3 check write latency
  task automatic send_frame(input logic [15:0] w, input int mode);
    lrck = 1'b0;
    for (int i = 15; i >= 1; i--) send_bit(w[i]);
    dat = w[0]; #40; bclk = 1'b1;
    #20;
    if (mode == 1) stop_a = 1'b1;
    #10;
    stop_a = 1'b0;
    if (mode == 1) check("a_we_suppressed", 36'(a_we_n), 36'd1);
    if (mode == 3) check("a_we_latency", 36'(a_we_n), 36'd0);
    if (mode == 2) begin
      check("a_we_before_rst", 36'(a_we_n), 36'd0);
      rst = 1'b1;
    end
    #10;
    rst = 1'b0;
    bclk = 1'b0;
    if (mode == 2) begin
      check("rst_mid_we_n", 36'(a_we_n), 36'd1);
      check("rst_mid_addr", 36'(a_addr), 36'd0);
      check("rst_mid_state", 36'(a_state), 36'd0);
    end
    lrck = 1'b1;
    for (int i = 15; i >= 0; i--) send_bit(~w[i]);
  endtask

  initial begin
    rst = 1; bclk = 0; lrck = 1; dat = 0;
    start_a = 0; pause_a = 0; stop_a = 0; start_b = 0; pause_b = 0; stop_b = 0;
    #10; bclk = 1; #10; bclk = 0; rst = 0;
    #10;
    check("rst_state", 36'(a_state), 36'd0);
    check("rst_addr", 36'(a_addr), 36'd0);
    check("rst_we_n", 36'(a_we_n), 36'd1);
    check("rst_rec", 36'(a_rec), 36'd0);
    check("rst_sram", {a_sram_addr, a_sram_data}, 36'd0);
    check("rst_full", 36'(a_full), 36'd0);

    // record three frames
    cmd(1, 0, 0, 0, 0, 0);
    check("start_state", 36'(a_state), 36'h5);
    q_a.push_back({20'd0, 16'hA5C3});
    q_a.push_back({20'd1, 16'h0001});
    q_a.push_back({20'd2, 16'h8000});
    send_frame(16'hA5C3, 3);
    send_frame(16'h0001, 0);
    send_frame(16'h8000, 0);
    #100;
    check("rec_pending", 36'(q_a.size()), 36'd0);
    check("rec_addr", 36'(a_addr), 36'd3);
    check("rec_data", 36'(a_rec), 36'h8000);
    check("rec_state", 36'(a_state), 36'h5);

    // pause after 7 bits, resume mid-frame, then one clean frame
    lrck = 0;
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    cmd(0, 1, 0, 0, 0, 0);
    check("pause_state", 36'(a_state), 36'h6);
    for (int i = 0; i < 9; i++) send_bit(1'b0);
    lrck = 1;
    for (int i = 0; i < 16; i++) send_bit(1'b1);
    check("pause_addr", 36'(a_addr), 36'd3);
    lrck = 0;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    cmd(0, 1, 0, 0, 0, 0);
    check("resume_state", 36'(a_state), 36'h5);
    for (int i = 0; i < 11; i++) send_bit(1'b0);
    lrck = 1;
    for (int i = 0; i < 16; i++) send_bit(1'b1);
    q_a.push_back({20'd3, 16'h1234});
    send_frame(16'h1234, 0);
    #100;
    check("resume_pending", 36'(q_a.size()), 36'd0);
    check("resume_addr", 36'(a_addr), 36'd4);
    check("resume_data", 36'(a_rec), 36'h1234);

    // command priority
    cmd(0, 0, 1, 0, 0, 0);
    check("stop_state", 36'(a_state), 36'd0);
    check("stop_hold_addr", 36'(a_addr), 36'd4);
    check("stop_hold_data", 36'(a_rec), 36'h1234);
    cmd(1, 0, 1, 0, 0, 0);
    check("start_stop_state", 36'(a_state), 36'd0);
    check("start_stop_addr", 36'(a_addr), 36'd4);
    cmd(1, 0, 0, 0, 0, 0);
    check("restart_addr", 36'(a_addr), 36'd0);
    check("restart_data", 36'(a_rec), 36'd0);
    cmd(0, 1, 1, 0, 0, 0);
    check("pause_stop_state", 36'(a_state), 36'd0);
    cmd(1, 0, 0, 0, 0, 0);
    q_a.push_back({20'd0, 16'h5A5A});
    send_frame(16'h5A5A, 0);
    send_frame(16'h0F0F, 1);
    #100;
    check("stop_done_state", 36'(a_state), 36'd0);
    check("stop_done_addr", 36'(a_addr), 36'd1);
    check("stop_done_data", 36'(a_rec), 36'h5A5A);
    check("stop_done_pending", 36'(q_a.size()), 36'd0);

    // reset lands on the write cycle
    cmd(1, 0, 0, 0, 0, 0);
    q_a.push_back({20'd0, 16'hC3C3});
    send_frame(16'hC3C3, 2);
    check("rst_mid_rec", 36'(a_rec), 36'd0);
    check("rst_mid_pending", 36'(q_a.size()), 36'd0);

    // saturation on the ADDR_MAX=2 instance
    cmd(0, 0, 0, 1, 0, 0);
    check("b_start_state", 36'(b_state), 36'h5);
    q_b.push_back({20'd0, 16'h1111});
    q_b.push_back({20'd1, 16'h2222});
    q_b.push_back({20'd2, 16'h3333});
    send_frame(16'h1111, 0);
    send_frame(16'h2222, 0);
    send_frame(16'h3333, 0);
    send_frame(16'h4444, 0);
    #100;
    check("b_pending", 36'(q_b.size()), 36'd0);
    check("b_full", 36'(b_full), 36'd1);
    check("b_full_state", 36'(b_state), 36'h4);
    check("b_full_addr", 36'(b_addr), 36'd2);
    cmd(0, 0, 0, 1, 0, 0);
    check("b_restart_addr", 36'(b_addr), 36'd0);
    check("b_restart_state", 36'(b_state), 36'h5);
    check("b_restart_full", 36'(b_full), 36'd0);
    check("a_idle_end", 36'(a_state), 36'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
